// File: rtl/fp_special_addsub_pipe.sv
// Special-operand resolver for IEEE-754 add/sub (zero/inf/NaN) in front of the normal-path adder.
// Latency: 2 cycles (S1 = operands + class, S2 = resolved result); 1 op/cycle throughput.
// Backpressure: both stages advance together when the output is free or taken; S1 may fill while S2 stalls.
module fp_special_addsub_pipe #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int TAG_W    = 4,
    parameter int NAN_MODE = 0,
    parameter int DAZ      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       out_result,
    output logic                       out_special,
    output logic                       out_invalid,
    output logic [TAG_W-1:0]           out_tag
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef enum logic [2:0] {
        C_ZERO   = 3'd0,
        C_FINITE = 3'd1,
        C_INF    = 3'd2,
        C_QNAN   = 3'd3,
        C_SNAN   = 3'd4
    } cls_t;

    localparam logic [W-1:0] QNAN_CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] QUIET_BIT  = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic cls_t classify(input logic [W-1:0] x);
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = &x[W-2:MAN_W];
        exp_zero = ~|x[W-2:MAN_W];
        man_zero = ~|x[MAN_W-1:0];
        if (exp_ones && man_zero)       return C_INF;
        else if (exp_ones)              return x[MAN_W-1] ? C_QNAN : C_SNAN;
        else if (exp_zero && man_zero)  return C_ZERO;
        else if (exp_zero)              return (DAZ != 0) ? C_ZERO : C_FINITE;
        else                            return C_FINITE;
    endfunction

    // With DAZ a subnormal leaving as a passthrough becomes a signed zero.
    function automatic logic [W-1:0] flush(input logic [W-1:0] x);
        if ((DAZ != 0) && (~|x[W-2:MAN_W])) return {x[W-1], {(W-1){1'b0}}};
        else                                return x;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    cls_t             s1_ca_q, s1_ca_d, s1_cb_q, s1_cb_d;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_result_q, out_result_d;
    logic             out_special_q, out_special_d;
    logic             out_invalid_q, out_invalid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             adv;
    logic             accept;
    logic [W-1:0]     res;
    logic             res_special;
    logic             res_invalid;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = (!s1_valid_q || adv) && !rst;
    assign accept   = in_valid && in_ready;

    // Resolve the S1 operand pair; first matching case wins.
    always_comb begin
        logic sa, sb, a_nan, b_nan;
        sa          = s1_a_q[W-1];
        sb          = s1_b_q[W-1] ^ s1_op_q;
        a_nan       = (s1_ca_q == C_QNAN) || (s1_ca_q == C_SNAN);
        b_nan       = (s1_cb_q == C_QNAN) || (s1_cb_q == C_SNAN);
        res         = '0;
        res_special = 1'b1;
        res_invalid = 1'b0;
        if (a_nan || b_nan) begin
            res_invalid = (s1_ca_q == C_SNAN) || (s1_cb_q == C_SNAN);
            if (NAN_MODE == 0) res = QNAN_CANON;
            else if (a_nan)    res = s1_a_q | QUIET_BIT;
            else               res = s1_b_q | QUIET_BIT;
        end else if ((s1_ca_q == C_INF) && (s1_cb_q == C_INF)) begin
            if (sa == sb) begin
                res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                res         = QNAN_CANON;
                res_invalid = 1'b1;
            end
        end else if (s1_ca_q == C_INF) begin
            res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_cb_q == C_INF) begin
            res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((s1_ca_q == C_ZERO) && (s1_cb_q == C_ZERO)) begin
            res = (sa == sb) ? {sa, {(W-1){1'b0}}} : '0;
        end else if (s1_ca_q == C_ZERO) begin
            res = flush({sb, s1_b_q[W-2:0]});
        end else if (s1_cb_q == C_ZERO) begin
            res = flush(s1_a_q);
        end else begin
            res_special = 1'b0;
        end
    end

    // Next-state for both stages: S1 loads on accept, S2 loads from S1 whenever the output advances.
    always_comb begin
        s1_valid_d    = accept ? 1'b1 : (adv ? 1'b0 : s1_valid_q);
        s1_a_d        = accept ? a : s1_a_q;
        s1_b_d        = accept ? b : s1_b_q;
        s1_op_d       = accept ? op : s1_op_q;
        s1_tag_d      = accept ? in_tag : s1_tag_q;
        s1_ca_d       = accept ? classify(a) : s1_ca_q;
        s1_cb_d       = accept ? classify(b) : s1_cb_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_special_d = out_special_q;
        out_invalid_d = out_invalid_q;
        out_tag_d     = out_tag_q;
        if (adv) begin
            out_valid_d   = s1_valid_q;
            out_result_d  = s1_valid_q ? res : '0;
            out_special_d = s1_valid_q && res_special;
            out_invalid_d = s1_valid_q && res_invalid;
            out_tag_d     = s1_valid_q ? s1_tag_q : '0;
        end
    end

    // Pipeline registers with synchronous reset that drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_op_q       <= 1'b0;
            s1_tag_q      <= '0;
            s1_ca_q       <= C_ZERO;
            s1_cb_q       <= C_ZERO;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_special_q <= 1'b0;
            out_invalid_q <= 1'b0;
            out_tag_q     <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_op_q       <= s1_op_d;
            s1_tag_q      <= s1_tag_d;
            s1_ca_q       <= s1_ca_d;
            s1_cb_q       <= s1_cb_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_special_q <= out_special_d;
            out_invalid_q <= out_invalid_d;
            out_tag_q     <= out_tag_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_special = out_special_q;
    assign out_invalid = out_invalid_q;
    assign out_tag     = out_tag_q;
endmodule

// File: tb/tb_fp_special_addsub_pipe.sv
// Directed bench for fp_special_addsub_pipe: single precision (both NaN modes) and a DAZ half-precision instance.
// Latency 2 cycles checked on every vector; stall, ordering and mid-flight reset checked explicitly.
// Backpressure driven by out_ready; all waits are fixed cycle counts.
module tb_fp_special_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, op, out_ready;
    logic [31:0] a, b;
    logic [15:0] ah, bh;
    logic [3:0]  tag;

    logic        in_ready, out_valid, out_special, out_invalid;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        in_ready_n, out_valid_n, out_special_n, out_invalid_n;
    logic [31:0] out_result_n;
    logic [3:0]  out_tag_n;
    logic        in_ready_h, out_valid_h, out_special_h, out_invalid_h;
    logic [15:0] out_result_h;
    logic [3:0]  out_tag_h;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_special_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .in_tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_special(out_special), .out_invalid(out_invalid), .out_tag(out_tag)
    );

    fp_special_addsub_pipe #(.NAN_MODE(1)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .a(a), .b(b), .op(op), .in_tag(tag),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_result(out_result_n),
        .out_special(out_special_n), .out_invalid(out_invalid_n), .out_tag(out_tag_n)
    );

    fp_special_addsub_pipe #(.EXP_W(5), .MAN_W(10), .DAZ(1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
        .a(ah), .b(bh), .op(op), .in_tag(tag),
        .out_valid(out_valid_h), .out_ready(out_ready), .out_result(out_result_h),
        .out_special(out_special_h), .out_invalid(out_invalid_h), .out_tag(out_tag_h)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One op through an idle pipeline with out_ready high; returns #1 after the output edge.
    task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic o,
                          input logic [3:0] t, input logic [15:0] ha, input logic [15:0] hb);
        a = aa; b = bb; op = o; tag = t; ah = ha; bh = hb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ah = '0; bh = '0; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_special", {31'b0, out_special}, 32'd0);
        check("rst_invalid", {31'b0, out_invalid}, 32'd0);
        check("rst_tag", {28'b0, out_tag}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        run_op(32'h0000_0000, 32'h3F80_0000, 1'b1, 4'd3, 16'h0, 16'h0);
        check("zero_minus_one_valid", {31'b0, out_valid}, 32'd1);
        check("zero_minus_one_res", out_result, 32'hBF80_0000);
        check("zero_minus_one_spec", {31'b0, out_special}, 32'd1);
        check("zero_minus_one_inv", {31'b0, out_invalid}, 32'd0);
        check("zero_minus_one_tag", {28'b0, out_tag}, 32'd3);

        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 4'd4, 16'h0, 16'h0);
        check("inf_sub_inf_res", out_result, 32'h7FC0_0000);
        check("inf_sub_inf_inv", {31'b0, out_invalid}, 32'd1);
        check("inf_sub_inf_nan1", out_result_n, 32'h7FC0_0000);
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 4'd5, 16'h0, 16'h0);
        check("inf_add_inf_res", out_result, 32'h7F80_0000);
        check("inf_add_inf_inv", {31'b0, out_invalid}, 32'd0);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd6, 16'h0, 16'h0);
        check("nz_plus_nz", out_result, 32'h8000_0000);
        run_op(32'h8000_0000, 32'h0000_0000, 1'b0, 4'd7, 16'h0, 16'h0);
        check("nz_plus_pz", out_result, 32'h0000_0000);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 4'd8, 16'h0, 16'h0);
        check("pz_minus_pz", out_result, 32'h0000_0000);
        check("pz_minus_pz_spec", {31'b0, out_special}, 32'd1);

        run_op(32'hFF80_0001, 32'h3F80_0000, 1'b0, 4'd9, 16'h0, 16'h0);
        check("snan_canon_res", out_result, 32'h7FC0_0000);
        check("snan_canon_inv", {31'b0, out_invalid}, 32'd1);
        check("snan_prop_res", out_result_n, 32'hFFC0_0001);
        check("snan_prop_inv", {31'b0, out_invalid_n}, 32'd1);

        run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd10, 16'h0, 16'h0);
        check("fin_fin_spec", {31'b0, out_special}, 32'd0);
        check("fin_fin_res", out_result, 32'd0);
        check("fin_fin_inv", {31'b0, out_invalid}, 32'd0);

        // Without DAZ a subnormal is finite and passes through untouched.
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 4'd11, 16'h0, 16'h0);
        check("subn_pass_res", out_result, 32'h0000_0001);

        run_op(32'h0, 32'h0, 1'b0, 4'd12, 16'h0001, 16'h3C00);
        check("h_daz_res", {16'b0, out_result_h}, 32'h3C00);
        check("h_daz_spec", {31'b0, out_special_h}, 32'd1);
        run_op(32'h0, 32'h0, 1'b0, 4'd13, 16'h7C00, 16'hFC00);
        check("h_inf_ninf_res", {16'b0, out_result_h}, 32'h7E00);
        check("h_inf_ninf_inv", {31'b0, out_invalid_h}, 32'd1);

        // Drain, then stream with the output stalled.
        @(posedge clk); #1;
        check("drained", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0; a = 32'h0; op = 1'b0;
        b = 32'h3F80_0001; tag = 4'd1; in_valid = 1'b1;
        check("bp_rdy_first", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_rdy_second", {31'b0, in_ready}, 32'd1);
        b = 32'h3F80_0002; tag = 4'd2;
        @(posedge clk); #1;
        check("bp_rdy_full", {31'b0, in_ready}, 32'd0);
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_tag1", {28'b0, out_tag}, 32'd1);
        b = 32'h3F80_0003; tag = 4'd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("bp_hold_tag", {28'b0, out_tag}, 32'd1);
            check("bp_hold_res", out_result, 32'h3F80_0001);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_tag2", {28'b0, out_tag}, 32'd2);
        check("bp_res2", out_result, 32'h3F80_0002);
        b = 32'h3F80_0004; tag = 4'd4;
        @(posedge clk); #1;
        check("bp_tag3", {28'b0, out_tag}, 32'd3);
        check("bp_res3", out_result, 32'h3F80_0003);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_tag4", {28'b0, out_tag}, 32'd4);
        check("bp_res4", out_result, 32'h3F80_0004);
        @(posedge clk); #1;
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Reset with two ops in flight.
        b = 32'h3F80_0005; tag = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        b = 32'h3F80_0006; tag = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_in_ready", {31'b0, in_ready}, 32'd0);
        check("mrst_tag", {28'b0, out_tag}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mrst_no_stale", {31'b0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
